// File: rtl/ticker_decoder.sv
// ticker_decoder: receive-side decoder for the 40-bit scrolling ticker window.
// Recovers each newly shifted-in 5-bit code, maps it to a byte, queues it in a
// first-word-fall-through FIFO and flags message ends, bad shifts and bad codes.
// Optional feature macro: TICKER_DECODER_ASCII_EN (ASCII output map; raw codes
// when undefined).
module ticker_decoder #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned GAP_LEN = 4
) (
    input  logic        sec_clock,
    input  logic        rst,
    input  logic [39:0] window,
    input  logic        char_ready,
    output logic        char_valid,
    output logic [7:0]  char_data,
    output logic        msg_done,
    output logic [7:0]  msg_len,
    output logic        shift_err,
    output logic        bad_code,
    output logic        overflow
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  GAP_MAX = 4'(GAP_LEN);

    typedef enum logic {SEED, TRACK} state_t;

    state_t          state_q;
    logic [39:0]     prev_q;
    logic [3:0]      gap_q;
    logic [7:0]      run_len_q;
    logic            armed_q;
    logic [7:0]      msg_len_q;
    logic            msg_done_q;
    logic            shift_err_q;
    logic            bad_code_q;
    logic            overflow_q;
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic [7:0]      mem_q [DEPTH];

    logic [4:0]      code;
    logic            is_hold;
    logic            is_shift;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push_d;
    logic            quiet_d;
    logic            accept_d;
    logic            drop_d;
    logic            msg_done_d;
    logic [3:0]      gap_d;
    logic [7:0]      push_byte_d;

    assign code       = window[4:0];
    assign is_hold    = (window == prev_q);
    assign is_shift   = (window[39:5] == prev_q[34:0]) && !is_hold;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop        = char_valid && char_ready;

    assign char_valid = !fifo_empty;
    assign char_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign msg_done   = msg_done_q;
    assign msg_len    = msg_len_q;
    assign shift_err  = shift_err_q;
    assign bad_code   = bad_code_q;
    assign overflow   = overflow_q;

    // Classify the current window against the previous one and decide push/quiet.
    always_comb begin
        push_d      = 1'b0;
        quiet_d     = 1'b0;
        push_byte_d = 8'h00;
        if (state_q == TRACK) begin
            if (is_hold) begin
                quiet_d = 1'b1;
            end else if (is_shift) begin
                if (code != 5'd0) begin
                    push_d = 1'b1;
                end else begin
                    quiet_d = 1'b1;
                    push_d  = (gap_q == 4'd0) && armed_q;
                end
            end
        end
`ifdef TICKER_DECODER_ASCII_EN
        if (code == 5'd0)
            push_byte_d = 8'h20;
        else if (code <= 5'd26)
            push_byte_d = 8'h40 + {3'b000, code};
        else
            push_byte_d = 8'h3F;
`else
        push_byte_d = {3'b000, code};
`endif
        gap_d      = (gap_q == GAP_MAX) ? gap_q : gap_q + 4'd1;
        msg_done_d = quiet_d && armed_q && (gap_d == GAP_MAX);
        // A full FIFO still accepts when the head leaves on the same edge.
        accept_d   = push_d && (!fifo_full || pop);
        drop_d     = push_d && fifo_full && !pop;
    end

    // Control FSM, message tracking, FIFO pointers and registered flags.
    always_ff @(posedge sec_clock) begin
        if (rst) begin
            state_q     <= SEED;
            prev_q      <= '0;
            gap_q       <= '0;
            run_len_q   <= '0;
            armed_q     <= 1'b0;
            msg_len_q   <= '0;
            msg_done_q  <= 1'b0;
            shift_err_q <= 1'b0;
            bad_code_q  <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            msg_done_q  <= 1'b0;
            shift_err_q <= 1'b0;
            bad_code_q  <= 1'b0;
            case (state_q)
                SEED: begin
                    prev_q  <= window;
                    state_q <= TRACK;
                end
                TRACK: begin
                    prev_q      <= window;
                    shift_err_q <= !is_hold && !is_shift;
                    bad_code_q  <= is_shift && (code >= 5'd27);
                    if (is_shift && code != 5'd0) begin
                        gap_q     <= '0;
                        armed_q   <= 1'b1;
                        run_len_q <= (run_len_q == 8'hFF) ? run_len_q : run_len_q + 8'd1;
                    end else if (quiet_d) begin
                        gap_q <= gap_d;
                    end
                    if (msg_done_d) begin
                        msg_done_q <= 1'b1;
                        msg_len_q  <= run_len_q;
                        run_len_q  <= '0;
                        armed_q    <= 1'b0;
                    end
                end
                default: state_q <= SEED;
            endcase
            if (accept_d)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop_d)
                overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge sec_clock) begin
        if (!rst && accept_d)
            mem_q[wr_ptr_q[AW-1:0]] <= push_byte_d;
    end

endmodule

// File: tb/tb_ticker_decoder.sv
// Directed self-checking bench for ticker_decoder (DEPTH=8, GAP_LEN=4).
module tb_ticker_decoder;

    logic        sec_clock;
    logic        rst;
    logic [39:0] window;
    logic        char_ready;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        msg_done;
    logic [7:0]  msg_len;
    logic        shift_err;
    logic        bad_code;
    logic        overflow;

    logic [39:0] win;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [4:0] cc_msg [16] = '{5'd3, 5'd15, 5'd14, 5'd22, 5'd5, 5'd18, 5'd20, 5'd0,
                                5'd3, 5'd21, 5'd18, 5'd18, 5'd5, 5'd14, 5'd3, 5'd25};

    ticker_decoder #(.DEPTH(8), .GAP_LEN(4)) dut (
        .sec_clock  (sec_clock),
        .rst        (rst),
        .window     (window),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .msg_done   (msg_done),
        .msg_len    (msg_len),
        .shift_err  (shift_err),
        .bad_code   (bad_code),
        .overflow   (overflow)
    );

    initial sec_clock = 1'b0;
    always #5 sec_clock = ~sec_clock;

    // Expected output byte for a code in the configured output map.
    function automatic logic [7:0] exp_char(input logic [4:0] c);
`ifdef TICKER_DECODER_ASCII_EN
        if (c == 5'd0)  return 8'h20;
        if (c <= 5'd26) return 8'h40 + {3'b000, c};
        return 8'h3F;
`else
        return {3'b000, c};
`endif
    endfunction

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        window = win;
        @(posedge sec_clock);
        #1;
    endtask

    task automatic shift_in(input logic [4:0] c);
        win = {win[34:0], c};
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        win = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        char_ready = 1'b1;
        win        = '0;
        window     = '0;

        // Reset values
        tick();
        tick();
        check("rst_valid",   char_valid, 1'b0);
        check("rst_data",    char_data,  8'h00);
        check("rst_done",    msg_done,   1'b0);
        check("rst_len",     msg_len,    8'h00);
        check("rst_serr",    shift_err,  1'b0);
        check("rst_bad",     bad_code,   1'b0);
        check("rst_ovf",     overflow,   1'b0);

        // Seed with window 0, then C O N with one-cycle latency
        rst = 1'b0;
        tick();
        check("seed_valid", char_valid, 1'b0);
        shift_in(5'd3);
        check("con_v0", char_valid, 1'b1);
        check("con_d0", char_data,  exp_char(5'd3));
        shift_in(5'd15);
        check("con_v1", char_valid, 1'b1);
        check("con_d1", char_data,  exp_char(5'd15));
        shift_in(5'd14);
        check("con_v2", char_valid, 1'b1);
        check("con_d2", char_data,  exp_char(5'd14));
        tick();
        check("con_empty", char_valid, 1'b0);

        // Full message "CONVERT CURRENCY" + trailing space, msg_done after 4th quiet tick
        do_reset();
        for (int i = 0; i < 16; i++) begin
            shift_in(cc_msg[i]);
            check("cc_valid", char_valid, 1'b1);
            check("cc_data",  char_data,  exp_char(cc_msg[i]));
            check("cc_nodone", msg_done,  1'b0);
        end
        shift_in(5'd0);
        check("cc_sp_valid", char_valid, 1'b1);
        check("cc_sp_data",  char_data,  exp_char(5'd0));
        check("cc_sp_done",  msg_done,   1'b0);
        shift_in(5'd0);
        check("cc_q2_valid", char_valid, 1'b0);
        check("cc_q2_done",  msg_done,   1'b0);
        shift_in(5'd0);
        check("cc_q3_done",  msg_done,   1'b0);
        shift_in(5'd0);
        check("cc_q4_done",  msg_done,   1'b1);
        check("cc_len",      msg_len,    8'd15);
        shift_in(5'd0);
        check("cc_q5_done",  msg_done,   1'b0);
        check("cc_q5_valid", char_valid, 1'b0);

        // Overflow: 9 shifts into an 8-deep FIFO with no consumer
        do_reset();
        char_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            shift_in(5'(i));
            if (i == 8) check("ovf_before", overflow, 1'b0);
        end
        check("ovf_after", overflow, 1'b1);
        char_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf_drain_v", char_valid, 1'b1);
            check("ovf_drain_d", char_data,  exp_char(5'(i)));
            tick();
        end
        check("ovf_drained", char_valid, 1'b0);
        check("ovf_sticky",  overflow,   1'b1);

        // Full FIFO with simultaneous push and pop: nothing lost
        do_reset();
        check("full_ovf_clr", overflow, 1'b0);
        char_ready = 1'b0;
        for (int i = 1; i <= 8; i++) shift_in(5'(i));
        char_ready = 1'b1;
        shift_in(5'd9);
        check("full_pp_ovf",  overflow,  1'b0);
        check("full_pp_head", char_data, exp_char(5'd2));
        for (int i = 3; i <= 9; i++) begin
            tick();
            check("full_pp_d", char_data, exp_char(5'(i)));
        end
        tick();
        check("full_pp_empty", char_valid, 1'b0);

        // Illegal window change -> shift_err pulse, no push; then legal shift of 1
        do_reset();
        win = 40'h12345_67890;
        tick();
        check("serr_pulse", shift_err,  1'b1);
        check("serr_nopush", char_valid, 1'b0);
        shift_in(5'd1);
        check("serr_clear", shift_err,  1'b0);
        check("serr_v",     char_valid, 1'b1);
        check("serr_d",     char_data,  exp_char(5'd1));

        // Out-of-range code 28
        do_reset();
        shift_in(5'b11100);
        check("bad_pulse", bad_code,   1'b1);
        check("bad_v",     char_valid, 1'b1);
`ifdef TICKER_DECODER_ASCII_EN
        check("bad_d",     char_data,  8'h3F);
`else
        check("bad_d",     char_data,  8'h1C);
`endif
        tick();
        check("bad_clear", bad_code, 1'b0);

        // Reset mid-message with 3 queued characters
        do_reset();
        for (int i = 1; i <= 3; i++) shift_in(5'(i));
        char_ready = 1'b0;
        shift_in(5'd4);
        shift_in(5'd5);
        check("mid_pre_v", char_valid, 1'b1);
        check("mid_pre_d", char_data,  exp_char(5'd3));
        rst = 1'b1;
        tick();
        check("mid_rst_v",    char_valid, 1'b0);
        check("mid_rst_done", msg_done,   1'b0);
        check("mid_rst_serr", shift_err,  1'b0);
        check("mid_rst_bad",  bad_code,   1'b0);
        check("mid_rst_ovf",  overflow,   1'b0);
        check("mid_rst_len",  msg_len,    8'h00);
        rst = 1'b0;
        char_ready = 1'b1;
        tick();
        shift_in(5'd8);
        shift_in(5'd9);
        for (int i = 0; i < 3; i++) begin
            shift_in(5'd0);
            check("mid_nodone", msg_done, 1'b0);
        end
        shift_in(5'd0);
        check("mid_done", msg_done, 1'b1);
        check("mid_len",  msg_len,  8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
